// File: rtl/arb_pkg.sv
// Shared types and constants for the VRAM arbiter: owner tags, FSM state encoding,
// default bus widths and the helper that classifies a registered command for the tag pipe.
package arb_pkg;

  localparam int unsigned ARB_ADDR_W = 10;
  localparam int unsigned ARB_DATA_W = 12;
  localparam int unsigned WAIT_W     = 4;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_GAME = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VGA_OWN  = 2'd1,
    GAME_OWN = 2'd2
  } state_t;

  // Only reads return data, so writes are tagged as having no owner.
  function automatic owner_t cmd_tag(input state_t st, input logic we);
    owner_t tag;
    tag = OWN_NONE;
    if (st == VGA_OWN) begin
      tag = OWN_VGA;
    end else if (st == GAME_OWN && !we) begin
      tag = OWN_GAME;
    end
    return tag;
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// RD_LAT-deep shift register of owner tags; aligns each read command with the cycle
// its memory data becomes valid. Synchronous clear drops reads that are in flight.
module arb_tag_pipe
  import arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic   clk,
  input  logic   clr,
  input  owner_t tag_in,
  output owner_t tag_out
);

  localparam int unsigned PIPE_W = 2 * RD_LAT;

  logic [PIPE_W-1:0] pipe;

  generate
    if (RD_LAT == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (clr) begin
          pipe <= '0;
        end else begin
          pipe <= tag_in;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (clr) begin
          pipe <= '0;
        end else begin
          pipe <= {pipe[PIPE_W-3:0], tag_in};
        end
      end
    end
  endgenerate

  assign tag_out = owner_t'(pipe[PIPE_W-1 -: 2]);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port tile/board RAM arbiter between VGA fetch (priority) and the game engine,
// with a saturating wait counter that forces a game slot. Grant counters built only
// when ARB_STATS_EN is defined; otherwise the stat ports read 0.
module vram_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ARB_ADDR_W,
  parameter int unsigned DATA_W   = ARB_DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_ack,
  output logic              game_rvalid,
  output logic [DATA_W-1:0] game_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_vga,
  output logic [STAT_W-1:0] stat_game,
  output logic [STAT_W-1:0] stat_forced
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  owner_t            tag_in;
  owner_t            tag_out;

  // State tracks the owner of the command currently on the memory port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant selection; acks are held low during reset so nothing is consumed.
  always_comb begin
    vga_ack    = 1'b0;
    game_ack   = 1'b0;
    state_next = IDLE;
    wait_next  = wait_cnt;
    if (!rst) begin
      if (game_req && wait_cnt == WAIT_LIMIT) begin
        game_ack   = 1'b1;
        state_next = GAME_OWN;
      end else if (vga_req) begin
        vga_ack    = 1'b1;
        state_next = VGA_OWN;
      end else if (game_req) begin
        game_ack   = 1'b1;
        state_next = GAME_OWN;
      end
    end
    if (!game_req || game_ack) begin
      wait_next = '0;
    end else if (wait_cnt < WAIT_LIMIT) begin
      wait_next = wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_next;
    end
  end

  // Registered memory command; address and write data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= vga_ack | game_ack;
      mem_we <= game_ack & game_we;
      if (vga_ack) begin
        mem_addr <= vga_addr;
      end else if (game_ack) begin
        mem_addr  <= game_addr;
        mem_wdata <= game_wdata;
      end
    end
  end

  assign tag_in = cmd_tag(state, mem_we);

  arb_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .clr    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign vga_rvalid  = (tag_out == OWN_VGA);
  assign game_rvalid = (tag_out == OWN_GAME);
  assign vga_rdata   = mem_rdata;
  assign game_rdata  = mem_rdata;

`ifdef ARB_STATS_EN
  logic forced;

  assign forced = game_ack && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_vga    <= '0;
      stat_game   <= '0;
      stat_forced <= '0;
    end else begin
      if (vga_ack) begin
        stat_vga <= stat_vga + STAT_W'(1);
      end
      if (game_ack) begin
        stat_game <= stat_game + STAT_W'(1);
      end
      if (forced) begin
        stat_forced <= stat_forced + STAT_W'(1);
      end
    end
  end
`else
  assign stat_vga    = '0;
  assign stat_game   = '0;
  assign stat_forced = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (RD_LAT = 1, MAX_WAIT = 4) with a
// behavioural RAM whose contents start as addr ^ 0xFFF, except 0x123 = 0x5A5.
module tb_vram_arbiter;
  import arb_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 12;

  logic              clk;
  logic              rst;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_ack;
  logic              game_rvalid;
  logic [DATA_W-1:0] game_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       stat_vga;
  logic [15:0]       stat_game;
  logic [15:0]       stat_forced;

  int checks;
  int failures;

  logic [DATA_W-1:0] ram [1024];

  vram_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (1),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_ack    (vga_ack),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .game_req   (game_req),
    .game_we    (game_we),
    .game_addr  (game_addr),
    .game_wdata (game_wdata),
    .game_ack   (game_ack),
    .game_rvalid(game_rvalid),
    .game_rdata (game_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stat_vga   (stat_vga),
    .stat_game  (stat_game),
    .stat_forced(stat_forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 12'(i) ^ 12'hFFF;
    end
    ram[12'h123] = 12'h5A5;
    mem_rdata = '0;
  end

  // One-cycle-latency synchronous RAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [9:0]  exp_game_ack;
    logic [15:0] exp_sv;
    logic [15:0] exp_sg;
    logic [15:0] exp_sf;

    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    vga_req    = 1'b0;
    vga_addr   = '0;
    game_req   = 1'b0;
    game_we    = 1'b0;
    game_addr  = '0;
    game_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_vga_rvalid", 32'(vga_rvalid), 32'd0);
    chk("reset_game_rvalid", 32'(game_rvalid), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    chk("reset_wait", 32'(dut.wait_cnt), 32'd0);
    chk("reset_stat_vga", 32'(stat_vga), 32'd0);

    // VGA-only stream 0x005..0x007
    vga_req = 1'b1; vga_addr = 10'h005;
    #1;
    chk("vga0_ack", 32'(vga_ack), 32'd1);
    next_cycle();
    vga_addr = 10'h006;
    #1;
    chk("vga1_ack", 32'(vga_ack), 32'd1);
    chk("vga1_mem_en", 32'(mem_en), 32'd1);
    chk("vga1_mem_addr", 32'(mem_addr), 32'h005);
    chk("vga1_mem_we", 32'(mem_we), 32'd0);
    chk("vga1_rvalid", 32'(vga_rvalid), 32'd0);
    next_cycle();
    vga_addr = 10'h007;
    #1;
    chk("vga2_ack", 32'(vga_ack), 32'd1);
    chk("vga2_mem_addr", 32'(mem_addr), 32'h006);
    chk("vga2_rvalid", 32'(vga_rvalid), 32'd1);
    chk("vga2_rdata", 32'(vga_rdata), 32'hFFA);
    chk("vga2_game_rvalid", 32'(game_rvalid), 32'd0);
    next_cycle();
    vga_req = 1'b0;
    #1;
    chk("vga3_ack", 32'(vga_ack), 32'd0);
    chk("vga3_mem_addr", 32'(mem_addr), 32'h007);
    chk("vga3_rvalid", 32'(vga_rvalid), 32'd1);
    chk("vga3_rdata", 32'(vga_rdata), 32'hFF9);
    next_cycle();
    #1;
    chk("vga4_rvalid", 32'(vga_rvalid), 32'd1);
    chk("vga4_rdata", 32'(vga_rdata), 32'hFF8);
    chk("vga4_mem_en", 32'(mem_en), 32'd0);
    chk("vga4_mem_addr_hold", 32'(mem_addr), 32'h007);
    next_cycle();
    #1;
    chk("vga5_rvalid", 32'(vga_rvalid), 32'd0);

    // Single game write
    game_req = 1'b1; game_we = 1'b1; game_addr = 10'h3FF; game_wdata = 12'hABC;
    #1;
    chk("gw_game_ack", 32'(game_ack), 32'd1);
    chk("gw_vga_ack", 32'(vga_ack), 32'd0);
    next_cycle();
    game_req = 1'b0; game_we = 1'b0;
    #1;
    chk("gw_mem_en", 32'(mem_en), 32'd1);
    chk("gw_mem_we", 32'(mem_we), 32'd1);
    chk("gw_mem_addr", 32'(mem_addr), 32'h3FF);
    chk("gw_mem_wdata", 32'(mem_wdata), 32'hABC);
    chk("gw_game_ack_off", 32'(game_ack), 32'd0);
    next_cycle();
    #1;
    chk("gw_game_rvalid", 32'(game_rvalid), 32'd0);
    chk("gw_vga_rvalid", 32'(vga_rvalid), 32'd0);
    chk("gw_mem_en_off", 32'(mem_en), 32'd0);
    chk("gw_mem_we_off", 32'(mem_we), 32'd0);
    next_cycle();
    #1;
    chk("gw_game_rvalid2", 32'(game_rvalid), 32'd0);

    // Reset before contention so stats start from zero
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // Contention: both held for cycles 0..9, game forced in 4 and 9
    exp_game_ack = 10'b10_0001_0000;
    vga_req = 1'b1; vga_addr = 10'h040;
    game_req = 1'b1; game_we = 1'b0; game_addr = 10'h010;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("cont%0d_game_ack", c), 32'(game_ack), 32'(exp_game_ack[c]));
      chk($sformatf("cont%0d_vga_ack", c), 32'(vga_ack), 32'(!exp_game_ack[c]));
      chk($sformatf("cont%0d_exclusive", c), 32'(vga_ack & game_ack), 32'd0);
      next_cycle();
    end
    vga_req = 1'b0; game_req = 1'b0;
    #1;
`ifdef ARB_STATS_EN
    exp_sv = 16'd8; exp_sg = 16'd2; exp_sf = 16'd2;
`else
    exp_sv = 16'd0; exp_sg = 16'd0; exp_sf = 16'd0;
`endif
    chk("stat_vga", 32'(stat_vga), 32'(exp_sv));
    chk("stat_game", 32'(stat_game), 32'(exp_sg));
    chk("stat_forced", 32'(stat_forced), 32'(exp_sf));
    chk("cont_game_rvalid_last", 32'(game_rvalid), 32'd0);
    chk("cont_wait_cleared", 32'(dut.wait_cnt), 32'd0);
    next_cycle();
    #1;
    chk("cont_game_rvalid_tail", 32'(game_rvalid), 32'd1);
    chk("cont_game_rdata_tail", 32'(game_rdata), 32'(12'h010 ^ 12'hFFF));
    next_cycle();
    next_cycle();

    // Game read of 0x123
    game_req = 1'b1; game_we = 1'b0; game_addr = 10'h123;
    #1;
    chk("gr_game_ack", 32'(game_ack), 32'd1);
    next_cycle();
    game_req = 1'b0;
    #1;
    chk("gr_mem_we", 32'(mem_we), 32'd0);
    chk("gr_mem_addr", 32'(mem_addr), 32'h123);
    chk("gr_game_rvalid_early", 32'(game_rvalid), 32'd0);
    next_cycle();
    #1;
    chk("gr_game_rvalid", 32'(game_rvalid), 32'd1);
    chk("gr_game_rdata", 32'(game_rdata), 32'h5A5);
    chk("gr_vga_rvalid", 32'(vga_rvalid), 32'd0);
    next_cycle();
    #1;
    chk("gr_game_rvalid_off", 32'(game_rvalid), 32'd0);

    // Reset while a VGA read is in flight
    vga_req = 1'b1; vga_addr = 10'h020;
    #1;
    chk("rm_vga_ack", 32'(vga_ack), 32'd1);
    next_cycle();
    vga_req = 1'b0; rst = 1'b1;
    #1;
    chk("rm_vga_ack_in_rst", 32'(vga_ack), 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rm_vga_rvalid", 32'(vga_rvalid), 32'd0);
    chk("rm_mem_en", 32'(mem_en), 32'd0);
    chk("rm_state", 32'(dut.state), 32'(IDLE));
    chk("rm_wait", 32'(dut.wait_cnt), 32'd0);
    next_cycle();
    #1;
    chk("rm_vga_rvalid_later", 32'(vga_rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port board/tile RAM (1024 x 12) between two requesters: the VGA render fetch path and the game-logic engine (box moves, recursion-level updates).
- Sits inside Top, between both requesters and the BRAM.
- VGA has priority. A saturating wait counter guarantees the game engine a slot within MAX_WAIT cycles.
- Read data is routed back to its owner through a tag pipeline.

Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 12, memory data width (RGB444 / tile code)
- RD_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata (1..4)
- MAX_WAIT, 4, maximum number of consecutive cycles a pending game request can lose to VGA (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- vga_req  in  1  VGA read request (level)
- vga_addr  in  ADDR_W  VGA read address
- vga_ack  out  1  VGA request granted this cycle
- vga_rvalid  out  1  vga_rdata valid
- vga_rdata  out  DATA_W  VGA read data
- game_req  in  1  game request (level)
- game_we  in  1  1 = write, 0 = read
- game_addr  in  ADDR_W  game address
- game_wdata  in  DATA_W  game write data
- game_ack  out  1  game request granted this cycle
- game_rvalid  out  1  game_rdata valid (reads only)
- game_rdata  out  DATA_W  game read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stat_vga  out  16  VGA grant count (ARB_STATS_EN)
- stat_game  out  16  game grant count (ARB_STATS_EN)
- stat_forced  out  16  forced game grant count (ARB_STATS_EN)

Behaviour:
- At most one grant per cycle. Acks are combinational from req and internal registers. Requesters must not derive req from ack. A request is consumed at the clock edge ending its ack cycle.
- Grant rule in cycle N:
  - if game_req && wait == MAX_WAIT: grant game (forced)
  - else if vga_req: grant VGA
  - else if game_req: grant game
  - else: no grant
- Wait counter (4 bit):
  - increments when game_req && !game_ack, saturating at MAX_WAIT
  - clears on a game grant
  - clears on any cycle with game_req = 0
- Memory command is registered. A grant in cycle N drives mem_en = 1, mem_we, mem_addr, mem_wdata in cycle N+1. VGA grants always have mem_we = 0. With no grant, mem_en = 0 and mem_we = 0 in N+1; addr/wdata hold their last values.
- FSM state = owner of the registered command: IDLE, VGA_OWN, GAME_OWN. The next state follows the cycle-N grant (none -> IDLE).
- Tag pipeline, RD_LAT deep, carries the owner of each read command (writes carry OWN_NONE). In cycle N+1+RD_LAT the owner's rvalid = 1; the other port's rvalid = 0. vga_rdata and game_rdata both equal mem_rdata (unqualified outside rvalid).
- Total read latency: ack cycle to rvalid cycle = 1 + RD_LAT. Writes produce no rvalid.
- Reset: all outputs 0, state IDLE, wait = 0, tag pipe cleared, stats 0. Reads in flight when rst is asserted never produce rvalid.
- Back-to-back grants to the same port are allowed every cycle.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: stat_vga, stat_game and stat_forced count grants. They wrap at 16 bits and clear on rst. stat_forced counts grants taken through the wait == MAX_WAIT path.
- Undefined: the stat ports remain, tied to 0. No counter logic is built.

Decomposition:
- Package arb_pkg holds:
  - owner typedef: OWN_NONE = 2'd0, OWN_VGA = 2'd1, OWN_GAME = 2'd2
  - FSM state encoding
  - default ADDR_W / DATA_W constants
- One sub-module, arb_tag_pipe: parameterised RD_LAT-deep shift register of owner tags with synchronous clear.

Test Plan:
- VGA only: vga_req held, vga_addr 0x005, 0x006, 0x007 advancing per ack; memory model rdata = addr ^ 0xFFF, RD_LAT = 1. Required: vga_ack every cycle, mem_addr one cycle later, vga_rvalid two cycles after each ack with vga_rdata 0xFFA, 0xFF9, 0xFF8.
- Game write: game_req = 1, game_we = 1, addr 0x3FF, wdata 0xABC, one cycle. Required: game_ack in cycle N; mem_en = 1, mem_we = 1, mem_addr = 0x3FF, mem_wdata = 0xABC in N+1; no rvalid on either port.
- Contention with MAX_WAIT = 4: vga_req and game_req held for cycles 0..9. Required: vga_ack in cycles 0-3 and 5-8; game_ack in cycles 4 and 9; never both acks high together.
- Game read: addr 0x123, memory returns 0x5A5. Required: game_rvalid = 1 with game_rdata 0x5A5 at ack + 2; vga_rvalid stays 0.
- Reset mid-op: VGA read acked in cycle N, rst = 1 in cycle N+1. Required: no vga_rvalid at N+2; mem_en = 0, wait = 0, state IDLE after reset.
- With ARB_STATS_EN, after the contention test: stat_vga = 8, stat_game = 2, stat_forced = 2. Without the macro, all three read 0.
